// File: rtl/sar_adc_controller.sv
// Successive-approximation controller: drives the S&H, runs an MSB-first binary
// search on the DAC code from the comparator, and strobes each finished result.
module sar_adc_controller #(
  parameter int N_BITS        = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic              cmp_in,
  output logic              sh_sample,
  output logic [N_BITS-1:0] dac_code,
  output logic [N_BITS-1:0] result,
  output logic              valid,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    TRIAL  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // One counter serves both the sample window and the per-bit settle window.
  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES + 1) ? SAMPLE_CYCLES
                                                               : SETTLE_CYCLES + 1;
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW = $clog2(N_BITS);

  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES);
  localparam logic [IW-1:0] MSB_IDX     = IW'(N_BITS - 1);

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [IW-1:0]     bit_idx, bit_nx;
  logic [N_BITS-1:0] code_nx, result_nx, trial_code;

  // Decision for the bit under test, with the next lower bit already set.
  always_comb begin
    trial_code = dac_code;
    if (!cmp_in) trial_code[bit_idx] = 1'b0;
    if (bit_idx != '0) trial_code[bit_idx - 1'b1] = 1'b1;
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    bit_nx    = bit_idx;
    code_nx   = dac_code;
    result_nx = result;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = SAMPLE;
          cnt_nx   = '0;
          code_nx  = '0;
        end
      end
      SAMPLE: begin
        if (cnt == SAMPLE_LAST) begin
          state_nx        = TRIAL;
          cnt_nx          = '0;
          bit_nx          = MSB_IDX;
          code_nx         = '0;
          code_nx[N_BITS-1] = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      TRIAL: begin
        if (cnt == SETTLE_LAST) begin
          cnt_nx  = '0;
          code_nx = trial_code;
          if (bit_idx == '0) begin
            state_nx  = DONE;
            result_nx = trial_code;
          end else begin
            bit_nx = bit_idx - 1'b1;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DONE: begin
        if (cont) begin
          state_nx = SAMPLE;
          cnt_nx   = '0;
          code_nx  = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      dac_code <= '0;
      result   <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      bit_idx  <= bit_nx;
      dac_code <= code_nx;
      result   <= result_nx;
    end
  end

  assign sh_sample = (state == SAMPLE);
  assign valid     = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sar_adc_controller.sv
// Bench for sar_adc_controller: ideal comparator (vin >= dac_code) and a
// cycle-indexed reference of the binary search, timed from the start cycle.
module tb_sar_adc_controller;

  logic       clk;
  logic       rst, start, cont, cmp_in, sh_sample, valid, busy;
  logic [7:0] dac_code, result, vin;

  logic       start6, cont6, cmp6, sh6, valid6, busy6;
  logic [3:0] dac6, res6, vin6;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  sar_adc_controller dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .cmp_in(cmp_in),
    .sh_sample(sh_sample), .dac_code(dac_code), .result(result),
    .valid(valid), .busy(busy)
  );

  sar_adc_controller #(.N_BITS(4), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(0)) dut6 (
    .clk(clk), .rst(rst), .start(start6), .cont(cont6), .cmp_in(cmp6),
    .sh_sample(sh6), .dac_code(dac6), .result(res6),
    .valid(valid6), .busy(busy6)
  );

  assign cmp_in = (vin >= dac_code);
  assign cmp6   = (vin6 >= dac6);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Code on the DAC while bit i is under test: bits above i already resolved to v.
  function automatic int trial(input int v, input int i);
    return ((v >> (i + 1)) << (i + 1)) | (1 << i);
  endfunction

  // {sh_sample, busy, valid, dac_code} k cycles after the edge that took start.
  function automatic logic [10:0] ref_vec8(input logic [7:0] v, input int k);
    if (k <= 4)       return {3'b110, 8'h00};
    else if (k <= 20) return {3'b010, 8'(trial(int'(v), 7 - (k - 5) / 2))};
    else if (k == 21) return {3'b011, v};
    else              return {3'b000, v};
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++;
    if ({sh_sample, busy, valid, dac_code, result} !== 19'h0) begin
      errors++;
      $display("FAIL reset: got %h expected 0", {sh_sample, busy, valid, dac_code, result});
    end
    checks++;
    if ({sh6, busy6, valid6, dac6, res6} !== 11'h0) begin
      errors++;
      $display("FAIL reset_small: got %h expected 0", {sh6, busy6, valid6, dac6, res6});
    end
    rst = 1'b0;
    tick;
  endtask

  // One conversion of v; start is re-pulsed after cycles p1/p2 (0 = never).
  task automatic run_conv(input logic [7:0] v, input int p1, input int p2);
    logic [10:0] act, expv;
    logic [7:0]  want;
    int nvalid;
    vin = v;
    exp_q.push_back(v);
    start = 1'b1;
    tick;
    start = 1'b0;
    nvalid = 0;
    for (int k = 1; k <= 23; k++) begin
      expv = ref_vec8(v, k);
      act  = {sh_sample, busy, valid, dac_code};
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL conv v=%h cycle %0d: got %h expected %h", v, k, act, expv);
      end
      if (valid === 1'b1) begin
        nvalid++;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (result !== want) begin
          errors++;
          $display("FAIL result v=%h: got %h expected %h", v, result, want);
        end
      end
      start = (k == p1 || k == p2);
      tick;
    end
    start = 1'b0;
    checks++;
    if (nvalid != 1) begin
      errors++;
      $display("FAIL valid_count v=%h: got %0d expected 1", v, nvalid);
    end
  endtask

  task automatic test_basic;
    run_conv(8'hA5, 0, 0);
  endtask

  task automatic test_extremes;
    run_conv(8'h00, 0, 0);
    run_conv(8'hFF, 0, 0);
  endtask

  task automatic test_start_while_busy;
    run_conv(8'h3C, 5, 12);
  endtask

  task automatic test_random;
    for (int n = 0; n < 16; n++)
      run_conv(8'($urandom_range(0, 255)), $urandom_range(0, 20), 0);
  endtask

  task automatic test_reset_mid;
    int nvalid;
    vin = 8'h5A;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k < 10; k++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if ({sh_sample, busy, valid, dac_code, result} !== 19'h0) begin
      errors++;
      $display("FAIL reset_mid: got %h expected 0", {sh_sample, busy, valid, dac_code, result});
    end
    nvalid = 0;
    for (int k = 12; k <= 24; k++) begin
      if (valid !== 1'b0 || busy !== 1'b0) nvalid++;
      tick;
    end
    checks++;
    if (nvalid != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", nvalid);
    end
  endtask

  task automatic test_cont;
    logic [7:0] want;
    logic       exp_valid;
    cont = 1'b1;
    vin  = 8'h12;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'hE7);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      exp_valid = (k == 21 || k == 42);
      checks++;
      if (valid !== exp_valid) begin
        errors++;
        $display("FAIL cont_valid cycle %0d: got %b expected %b", k, valid, exp_valid);
      end
      if (valid === 1'b1) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (result !== want) begin
          errors++;
          $display("FAIL cont_result cycle %0d: got %h expected %h", k, result, want);
        end
      end
      if (k == 22) begin
        checks++;
        if ({sh_sample, busy, dac_code} !== 10'b11_0000_0000) begin
          errors++;
          $display("FAIL cont_restart: got %h expected 300", {sh_sample, busy, dac_code});
        end
      end
      if (k == 43 || k == 45) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL cont_stop cycle %0d: got busy %b expected 0", k, busy);
        end
      end
      if (k == 21) vin = 8'hE7;
      if (k == 30) cont = 1'b0;
      tick;
    end
  endtask

  task automatic test_small;
    logic [6:0] act, expv;
    logic [3:0] v;
    for (int n = 0; n < 6; n++) begin
      v = (n == 0) ? 4'h9 : 4'($urandom_range(0, 15));
      vin6 = v;
      start6 = 1'b1;
      tick;
      start6 = 1'b0;
      for (int k = 1; k <= 11; k++) begin
        if (k <= 4)      expv = {3'b110, 4'h0};
        else if (k <= 8) expv = {3'b010, 4'(trial(int'(v), 3 - (k - 5)))};
        else if (k == 9) expv = {3'b011, v};
        else             expv = {3'b000, v};
        act = {sh6, busy6, valid6, dac6};
        checks++;
        if (act !== expv) begin
          errors++;
          $display("FAIL small v=%h cycle %0d: got %h expected %h", v, k, act, expv);
        end
        if (k == 9) begin
          checks++;
          if (res6 !== v) begin
            errors++;
            $display("FAIL small_result: got %h expected %h", res6, v);
          end
        end
        tick;
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cont = 1'b0; vin = 8'h00;
    start6 = 1'b0; cont6 = 1'b0; vin6 = 4'h0;
    test_reset;
    test_basic;
    test_extremes;
    test_start_while_busy;
    test_random;
    test_reset_mid;
    test_cont;
    test_small;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
